// File: rtl/pls_pkg.sv
// Shared definitions for the PLS/GMII symbol mapping (transmit mapper and receive decoder).
// One-hot PLS symbol encodings, GMII code points and the receive frame-state encoding.
package pls_pkg;

  typedef logic [4:0] sym_t;

  localparam sym_t SYM_NONE          = 5'b00000;
  localparam sym_t SYM_ZERO          = 5'b00001;
  localparam sym_t SYM_ONE           = 5'b00010;
  localparam sym_t SYM_EXTEND_ERROR  = 5'b00100;
  localparam sym_t SYM_EXTEND        = 5'b01000;
  localparam sym_t SYM_DATA_COMPLETE = 5'b10000;

  localparam logic [7:0] GMII_ZERO          = 8'h4F;
  localparam logic [7:0] GMII_ONE           = 8'h3F;
  localparam logic [7:0] GMII_EXTEND_ERROR  = 8'h1F;
  localparam logic [7:0] GMII_EXTEND        = 8'h0F;
  localparam logic [7:0] GMII_DATA_COMPLETE = 8'h5F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_EXT  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/pls_sym_decode.sv
// Combinational GMII receive code to one-hot PLS symbol decoder.
// Exact match on {rx_dv, rx_er, rxd}; anything unmatched decodes to SYM_NONE with invalid set.
module pls_sym_decode
  import pls_pkg::*;
(
  input  logic [7:0] rxd,
  input  logic       rx_dv,
  input  logic       rx_er,
  output sym_t       sym,
  output logic       invalid
);

  always_comb begin
    sym = SYM_NONE;
    case ({rx_dv, rx_er})
      2'b10: begin
        if (rxd == GMII_ZERO)      sym = SYM_ZERO;
        else if (rxd == GMII_ONE)  sym = SYM_ONE;
      end
      2'b01: begin
        if (rxd == GMII_EXTEND_ERROR) sym = SYM_EXTEND_ERROR;
        else if (rxd == GMII_EXTEND)  sym = SYM_EXTEND;
      end
      2'b00: begin
        if (rxd == GMII_DATA_COMPLETE) sym = SYM_DATA_COMPLETE;
      end
      default: sym = SYM_NONE;
    endcase
  end

  assign invalid = (sym == SYM_NONE);

endmodule

// File: rtl/pls_rx_decoder.sv
// Receive-side PLS decoder: registers GMII inputs, decodes them and tracks frame state,
// data-symbol count and error status, reporting each completed frame to the upper layer.
module pls_rx_decoder
  import pls_pkg::*;
#(
  parameter int SYM_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rxd,
  input  logic                 rx_dv,
  input  logic                 rx_er,
  output logic [4:0]           pls_data_ind,
  output logic                 pls_ind_valid,
  output logic                 pls_carrier,
  output logic                 frame_done,
  output logic [SYM_CNT_W-1:0] frame_len,
  output logic                 frame_err
);

  localparam logic [SYM_CNT_W-1:0] CNT_ONE = SYM_CNT_W'(1);

  logic [7:0]           rxd_q;
  logic                 rx_dv_q;
  logic                 rx_er_q;
  sym_t                 sym;
  logic                 invalid;
  logic                 is_data;
  state_t               state;
  logic [SYM_CNT_W-1:0] cnt;
  logic [SYM_CNT_W-1:0] cnt_inc;
  logic                 err_flag;

  // Input stage clears to the idle pattern so reset looks like an idle line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_q   <= GMII_DATA_COMPLETE;
      rx_dv_q <= 1'b0;
      rx_er_q <= 1'b0;
    end else begin
      rxd_q   <= rxd;
      rx_dv_q <= rx_dv;
      rx_er_q <= rx_er;
    end
  end

  pls_sym_decode u_decode (
    .rxd     (rxd_q),
    .rx_dv   (rx_dv_q),
    .rx_er   (rx_er_q),
    .sym     (sym),
    .invalid (invalid)
  );

  assign is_data = (sym == SYM_ZERO) || (sym == SYM_ONE);
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_ONE;

  // Carrier covers the whole frame, from the first data symbol through the closing DATA_COMPLETE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      err_flag      <= 1'b0;
      pls_data_ind  <= SYM_NONE;
      pls_ind_valid <= 1'b0;
      pls_carrier   <= 1'b0;
      frame_done    <= 1'b0;
      frame_len     <= '0;
      frame_err     <= 1'b0;
    end else begin
      pls_data_ind  <= sym;
      pls_ind_valid <= 1'b0;
      pls_carrier   <= (state != ST_IDLE);
      frame_done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (is_data) begin
            state         <= ST_DATA;
            cnt           <= CNT_ONE;
            pls_ind_valid <= 1'b1;
            pls_carrier   <= 1'b1;
          end
        end
        ST_DATA: begin
          if (is_data) begin
            cnt           <= cnt_inc;
            pls_ind_valid <= 1'b1;
          end else if (sym == SYM_EXTEND) begin
            state         <= ST_EXT;
            pls_ind_valid <= 1'b1;
          end else if (sym == SYM_EXTEND_ERROR) begin
            state         <= ST_EXT;
            err_flag      <= 1'b1;
            pls_ind_valid <= 1'b1;
          end else if (sym == SYM_DATA_COMPLETE) begin
            state         <= ST_IDLE;
            err_flag      <= 1'b0;
            pls_ind_valid <= 1'b1;
            frame_done    <= 1'b1;
            frame_len     <= cnt;
            frame_err     <= err_flag;
          end else if (invalid) begin
            state    <= ST_ERR;
            err_flag <= 1'b1;
          end
        end
        ST_EXT: begin
          if (sym == SYM_EXTEND) begin
            pls_ind_valid <= 1'b1;
          end else if (sym == SYM_EXTEND_ERROR) begin
            err_flag      <= 1'b1;
            pls_ind_valid <= 1'b1;
          end else if (sym == SYM_DATA_COMPLETE) begin
            state         <= ST_IDLE;
            err_flag      <= 1'b0;
            pls_ind_valid <= 1'b1;
            frame_done    <= 1'b1;
            frame_len     <= cnt;
            frame_err     <= err_flag;
          end else if (is_data || invalid) begin
            state    <= ST_ERR;
            err_flag <= 1'b1;
          end
        end
        ST_ERR: begin
          // Everything but DATA_COMPLETE is swallowed; the count stays frozen at the error point.
          if (sym == SYM_DATA_COMPLETE) begin
            state         <= ST_IDLE;
            err_flag      <= 1'b0;
            pls_ind_valid <= 1'b1;
            frame_done    <= 1'b1;
            frame_len     <= cnt;
            frame_err     <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pls_rx_decoder.sv
// Directed bench for pls_rx_decoder: expectations are queued when a symbol is driven and
// compared two cycles later; a second instance with a 4-bit counter covers saturation.
module tb_pls_rx_decoder;

  localparam logic [4:0] I_NONE = 5'b00000;
  localparam logic [4:0] I_ZERO = 5'b00001;
  localparam logic [4:0] I_ONE  = 5'b00010;
  localparam logic [4:0] I_EE   = 5'b00100;
  localparam logic [4:0] I_EXT  = 5'b01000;
  localparam logic [4:0] I_DC   = 5'b10000;

  typedef struct packed {
    logic [4:0]  ind;
    logic        valid;
    logic        carrier;
    logic        done;
    logic [15:0] len;
    logic        err;
    logic [3:0]  len4;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rxd = 8'h5F;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;

  logic [4:0]  pls_data_ind;
  logic        pls_ind_valid;
  logic        pls_carrier;
  logic        frame_done;
  logic [15:0] frame_len;
  logic        frame_err;

  logic [4:0]  d4_data_ind;
  logic        d4_ind_valid;
  logic        d4_carrier;
  logic        d4_frame_done;
  logic [3:0]  d4_frame_len;
  logic        d4_frame_err;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pls_rx_decoder #(.SYM_CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .rxd           (rxd),
    .rx_dv         (rx_dv),
    .rx_er         (rx_er),
    .pls_data_ind  (pls_data_ind),
    .pls_ind_valid (pls_ind_valid),
    .pls_carrier   (pls_carrier),
    .frame_done    (frame_done),
    .frame_len     (frame_len),
    .frame_err     (frame_err)
  );

  pls_rx_decoder #(.SYM_CNT_W(4)) dut4 (
    .clk           (clk),
    .reset         (reset),
    .rxd           (rxd),
    .rx_dv         (rx_dv),
    .rx_er         (rx_er),
    .pls_data_ind  (d4_data_ind),
    .pls_ind_valid (d4_ind_valid),
    .pls_carrier   (d4_carrier),
    .frame_done    (d4_frame_done),
    .frame_len     (d4_frame_len),
    .frame_err     (d4_frame_err)
  );

  function automatic exp_t mk(input logic [4:0] ind, input logic valid, input logic carrier,
                              input logic done, input int len, input logic err);
    exp_t e;
    e.ind     = ind;
    e.valid   = valid;
    e.carrier = carrier;
    e.done    = done;
    e.len     = 16'(len);
    e.err     = err;
    e.len4    = (len > 15) ? 4'd15 : 4'(len);
    return e;
  endfunction

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic compare_all(input exp_t e);
    check_val("data_ind",  16'(pls_data_ind),  16'(e.ind));
    check_val("ind_valid", 16'(pls_ind_valid), 16'(e.valid));
    check_val("carrier",   16'(pls_carrier),   16'(e.carrier));
    check_val("frame_done", 16'(frame_done),   16'(e.done));
    check_val("frame_len", frame_len,          e.len);
    check_val("frame_err", 16'(frame_err),     16'(e.err));
    check_val("frame_len4", 16'(d4_frame_len), 16'(e.len4));
  endtask

  task automatic check_reset_zero();
    compare_all(mk(I_NONE, 1'b0, 1'b0, 1'b0, 0, 1'b0));
  endtask

  // Drive one symbol per cycle; outputs for the symbol driven two steps ago are due now.
  task automatic step(input logic [7:0] d, input logic dv, input logic er, input exp_t e);
    exp_t x;
    @(negedge clk);
    if (sb.size() >= 2) begin
      x = sb.pop_front();
      compare_all(x);
    end
    rxd   = d;
    rx_dv = dv;
    rx_er = er;
    sb.push_back(e);
  endtask

  task automatic idle(input int n, input int len, input logic err);
    for (int i = 0; i < n; i++) step(8'h5F, 1'b0, 1'b0, mk(I_DC, 1'b0, 1'b0, 1'b0, len, err));
  endtask

  initial begin
    #3;
    check_reset_zero();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    idle(10, 0, 1'b0);

    step(8'h4F, 1'b1, 1'b0, mk(I_ZERO, 1, 1, 0, 0, 0));
    step(8'h3F, 1'b1, 1'b0, mk(I_ONE,  1, 1, 0, 0, 0));
    step(8'h3F, 1'b1, 1'b0, mk(I_ONE,  1, 1, 0, 0, 0));
    step(8'h4F, 1'b1, 1'b0, mk(I_ZERO, 1, 1, 0, 0, 0));
    step(8'h5F, 1'b0, 1'b0, mk(I_DC,   1, 1, 1, 4, 0));
    idle(2, 4, 1'b0);

    for (int i = 0; i < 3; i++) step(8'h3F, 1'b1, 1'b0, mk(I_ONE, 1, 1, 0, 4, 0));
    step(8'h0F, 1'b0, 1'b1, mk(I_EXT, 1, 1, 0, 4, 0));
    step(8'h0F, 1'b0, 1'b1, mk(I_EXT, 1, 1, 0, 4, 0));
    step(8'h1F, 1'b0, 1'b1, mk(I_EE,  1, 1, 0, 4, 0));
    step(8'h5F, 1'b0, 1'b0, mk(I_DC,  1, 1, 1, 3, 1));
    idle(2, 3, 1'b1);

    step(8'h4F, 1'b1, 1'b0, mk(I_ZERO, 1, 1, 0, 3, 1));
    step(8'hAA, 1'b1, 1'b0, mk(I_NONE, 0, 1, 0, 3, 1));
    step(8'h3F, 1'b1, 1'b0, mk(I_ONE,  0, 1, 0, 3, 1));
    step(8'h3F, 1'b1, 1'b0, mk(I_ONE,  0, 1, 0, 3, 1));
    step(8'h5F, 1'b0, 1'b0, mk(I_DC,   1, 1, 1, 1, 1));
    idle(2, 1, 1'b1);

    // Back-to-back frames with the error status of the previous frame held until replaced.
    step(8'h4F, 1'b1, 1'b0, mk(I_ZERO, 1, 1, 0, 1, 1));
    step(8'h5F, 1'b0, 1'b0, mk(I_DC,   1, 1, 1, 1, 0));
    step(8'h4F, 1'b1, 1'b0, mk(I_ZERO, 1, 1, 0, 1, 0));
    step(8'h3F, 1'b1, 1'b0, mk(I_ONE,  1, 1, 0, 1, 0));
    step(8'h5F, 1'b0, 1'b0, mk(I_DC,   1, 1, 1, 2, 0));
    idle(2, 2, 1'b0);

    step(8'h3F, 1'b1, 1'b0, mk(I_ONE, 1, 1, 0, 2, 0));
    step(8'h0F, 1'b0, 1'b1, mk(I_EXT, 1, 1, 0, 2, 0));
    step(8'h3F, 1'b1, 1'b0, mk(I_ONE, 0, 1, 0, 2, 0));
    step(8'h5F, 1'b0, 1'b0, mk(I_DC,  1, 1, 1, 1, 1));
    step(8'h0F, 1'b0, 1'b1, mk(I_EXT, 0, 0, 0, 1, 1));
    idle(2, 1, 1'b1);

    for (int i = 0; i < 3; i++) step(8'h3F, 1'b1, 1'b0, mk(I_ONE, 1, 1, 0, 1, 1));
    #2;
    reset = 1'b0;
    rxd   = 8'h5F;
    rx_dv = 1'b0;
    rx_er = 1'b0;
    #1;
    check_reset_zero();
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    idle(2, 0, 1'b0);
    step(8'h4F, 1'b1, 1'b0, mk(I_ZERO, 1, 1, 0, 0, 0));
    step(8'h5F, 1'b0, 1'b0, mk(I_DC,   1, 1, 1, 1, 0));
    idle(2, 1, 1'b0);

    for (int i = 0; i < 20; i++) step(8'h3F, 1'b1, 1'b0, mk(I_ONE, 1, 1, 0, 1, 0));
    step(8'h5F, 1'b0, 1'b0, mk(I_DC, 1, 1, 1, 20, 0));
    idle(2, 20, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pls_rx_decoder.md
Name: pls_rx_decoder

Overview:
- Receive-side counterpart of the one-hot PLS-to-GMII transmit mapper: decodes GMII-style receive symbols (rxd/rx_dv/rx_er) back into one-hot PLS data indications.
- Tracks frame state (idle, data, extension, error), counts data symbols per frame and reports frame completion with length and error status to the upper layer.

Parameters:
- SYM_CNT_W, 16, width of the per-frame data-symbol counter and frame_len output (saturating).

Ports:
- clk  in  1  receive clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rxd  in  8  received data code.
- rx_dv  in  1  receive data valid.
- rx_er  in  1  receive error/extension flag.
- pls_data_ind  out  5  one-hot decoded symbol: 00001 ZERO, 00010 ONE, 00100 EXTEND_ERROR, 01000 EXTEND, 10000 DATA_COMPLETE, 00000 none/invalid.
- pls_ind_valid  out  1  high for one cycle per decoded frame symbol (not asserted for idle DATA_COMPLETE).
- pls_carrier  out  1  high while a frame is in progress (state DATA, EXT or ERR).
- frame_done  out  1  one-cycle pulse at end of frame.
- frame_len  out  SYM_CNT_W  count of ZERO/ONE symbols in the completed frame; valid with frame_done, held until next frame_done.
- frame_err  out  1  frame error status; valid with frame_done, held until next frame_done.

Behaviour:
- Reset (reset=0, async): all outputs 0, state IDLE, counter 0, input registers cleared to rxd=8'h5F, rx_dv=0, rx_er=0 (the idle pattern).
- Stage 1 registers rxd/rx_dv/rx_er. Stage 2 decodes and registers outputs. Input-to-output latency is exactly 2 clk cycles.
- Decode table (exact match on {rx_dv, rx_er, rxd}):
  - 1,0,4F -> ZERO
  - 1,0,3F -> ONE
  - 0,1,1F -> EXTEND_ERROR
  - 0,1,0F -> EXTEND
  - 0,0,5F -> DATA_COMPLETE
  - Any other combination -> INVALID: pls_data_ind=00000.
- FSM states: IDLE, DATA, EXT, ERR.
  - IDLE:
    - ZERO/ONE -> DATA; counter=1; valid=1.
    - DATA_COMPLETE -> stay in IDLE, valid=0.
    - EXTEND/EXTEND_ERROR/INVALID -> stay in IDLE, valid=0, ignored.
  - DATA:
    - ZERO/ONE -> stay; counter+1, saturating at all-ones.
    - EXTEND -> EXT.
    - EXTEND_ERROR -> EXT and set error flag.
    - DATA_COMPLETE -> IDLE; frame_done=1; latch frame_len and frame_err.
    - INVALID -> ERR and set error flag.
  - EXT:
    - EXTEND -> stay.
    - EXTEND_ERROR -> stay and set error flag.
    - DATA_COMPLETE -> IDLE with frame_done as above.
    - ZERO/ONE/INVALID -> ERR and set error flag.
  - ERR:
    - All symbols except DATA_COMPLETE -> stay, valid=0; counter frozen.
    - DATA_COMPLETE -> IDLE; frame_done=1; frame_err=1.
- pls_ind_valid=1 in the same cycle as pls_data_ind for every frame symbol accepted in DATA/EXT, including the terminating DATA_COMPLETE.
- The error flag clears on entry to IDLE. The counter clears when the next frame starts.
- pls_carrier is the registered state != IDLE and is aligned with pls_data_ind.
- Back-to-back frames: DATA_COMPLETE immediately followed by ZERO starts a new frame on the next cycle. frame_len/frame_err are held across this.
- Reset asserted mid-frame: immediate return to IDLE. No frame_done is generated, and previous frame_len/frame_err clear to 0.

Decomposition:
- Package pls_pkg holds:
  - One-hot symbol constants (SYM_ZERO..SYM_DATA_COMPLETE).
  - GMII code constants 8'h4F, 8'h3F, 8'h1F, 8'h0F, 8'h5F.
  - State encoding for IDLE/DATA/EXT/ERR.
  - The transmit mapper should share the same package.
- One natural sub-module, pls_sym_decode: combinational {rx_dv, rx_er, rxd} -> one-hot symbol plus invalid flag. The FSM, counter and registers stay in the top.

Test Plan:
- Reset then idle 5F with rx_dv=0, rx_er=0 for 10 cycles -> pls_carrier=0, pls_ind_valid=0, frame_done never pulses.
- Frame ZERO, ONE, ONE, ZERO, DATA_COMPLETE (rx_dv=1 on data) -> indications 00001, 00010, 00010, 00001, 10000, each 2 cycles after input; frame_done pulse with frame_len=4, frame_err=0.
- Frame ONE×3, EXTEND×2, EXTEND_ERROR, DATA_COMPLETE -> frame_len=3, frame_err=1, pls_carrier high from first ONE through DATA_COMPLETE.
- Frame ZERO, then rxd=8'hAA with rx_dv=1, then ONE×2, DATA_COMPLETE -> ERR entered, no valid on AA or the following ONEs, frame_len=1, frame_err=1.
- Mid-frame reset low for 1 cycle after 3 ONEs -> outputs 0 asynchronously, no frame_done; the next frame ZERO, DATA_COMPLETE gives frame_len=1.
- SYM_CNT_W=4 with 20 ONE symbols then DATA_COMPLETE -> frame_len=15 (saturated), frame_err=0.
